// File: rtl/drum_sequencer.sv
// 16-step, multi-voice drum pattern sequencer: pattern RAM, tempo-driven step clock,
// shared sample-rate enable and per-voice go/busy tracking.
module drum_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_STEPS  = 16,
  parameter int TEMPO_W    = 26,
  parameter int SAMPLE_DIV = 3125,
  parameter int VOICE_LEN  = 16481
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic [TEMPO_W-1:0]    tempo_div,
  input  logic                  pat_we,
  input  logic [1:0]            pat_voice,
  input  logic [3:0]            pat_step,
  input  logic                  pat_data,
  output logic [NUM_VOICES-1:0] voice_go,
  output logic                  sample_en,
  output logic [3:0]            step_idx,
  output logic                  step_tick,
  output logic                  running,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int SC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int VC_W = $clog2(VOICE_LEN + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [TEMPO_W-1:0]                   tempo_cnt_reg;
  logic [TEMPO_W-1:0]                   div_eff;
  logic [SC_W-1:0]                      sample_cnt_reg;
  logic                                 sample_en_reg;
  logic                                 step_tick_reg;
  logic [3:0]                           step_reg;
  logic [3:0]                           step_next;
  logic [NUM_VOICES-1:0]                voice_go_reg;
  logic [NUM_VOICES-1:0]                go_next;
  logic [NUM_VOICES-1:0]                active_reg;
  logic [NUM_VOICES-1:0][NUM_STEPS-1:0] pattern_reg;
  logic                                 arm_fire;
  logic                                 advance;
  logic                                 step_due;

  assign div_eff   = (tempo_div < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_div;
  assign step_due  = (tempo_cnt_reg >= div_eff - TEMPO_W'(1));
  assign step_next = (step_reg == 4'(NUM_STEPS - 1)) ? 4'd0 : step_reg + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // stop always has priority; a step advance in the stop cycle is dropped
  always_comb begin
    state_next = state_reg;
    arm_fire   = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE:  if (play && !stop) state_next = ARM;
      ARM: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
          arm_fire   = 1'b1;
        end
      end
      RUN: begin
        if (stop)          state_next = DRAIN;
        else if (step_due) advance    = 1'b1;
      end
      DRAIN: if (active_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tempo_cnt_reg <= '0;
      step_reg      <= '0;
      step_tick_reg <= 1'b0;
      voice_go_reg  <= '0;
    end else begin
      step_tick_reg <= arm_fire | advance;
      voice_go_reg  <= go_next;
      if (state_reg == ARM) begin
        step_reg      <= '0;
        tempo_cnt_reg <= '0;
      end else if (state_reg == RUN && !stop) begin
        if (step_due) begin
          tempo_cnt_reg <= '0;
          step_reg      <= step_next;
        end else begin
          tempo_cnt_reg <= tempo_cnt_reg + TEMPO_W'(1);
        end
      end
    end
  end

  // Pattern reads use the pre-edge contents, so a same-cycle write lands on the next visit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pattern_reg <= '0;
    else if (pat_we) pattern_reg[pat_voice][pat_step] <= pat_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt_reg <= '0;
      sample_en_reg  <= 1'b0;
    end else if (sample_cnt_reg == SC_W'(SAMPLE_DIV - 1)) begin
      sample_cnt_reg <= '0;
      sample_en_reg  <= 1'b1;
    end else begin
      sample_cnt_reg <= sample_cnt_reg + SC_W'(1);
      sample_en_reg  <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [VC_W-1:0] vcnt_reg;
      logic            act_reg;

      assign go_next[gi] = (arm_fire & pattern_reg[gi][0]) |
                           (advance  & pattern_reg[gi][step_next]);
      assign active_reg[gi] = act_reg;

      // go beats a coincident sample_en; the last tick clears busy on the same edge
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          act_reg  <= 1'b0;
          vcnt_reg <= '0;
        end else if (voice_go_reg[gi]) begin
          act_reg  <= 1'b1;
          vcnt_reg <= '0;
        end else if (act_reg && sample_en_reg) begin
          if (vcnt_reg == VC_W'(VOICE_LEN - 1)) begin
            act_reg  <= 1'b0;
            vcnt_reg <= '0;
          end else begin
            vcnt_reg <= vcnt_reg + VC_W'(1);
          end
        end
      end
    end
  endgenerate

  assign voice_go     = voice_go_reg;
  assign sample_en    = sample_en_reg;
  assign step_idx     = step_reg;
  assign step_tick    = step_tick_reg;
  assign running      = (state_reg == ARM) || (state_reg == RUN);
  assign voice_active = active_reg;

endmodule
